// File: rtl/seg7_pkg.sv
// Shared segment constants for the 7-segment scan driver.
// Codes are active-low in {a,b,c,d,e,f,g} order, so bit 6 is segment a.
// A 0 bit lights a segment, and SEG_BLANK turns the whole digit off.
package seg7_pkg;

  localparam int SEG_W     = 7;
  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_encoder.sv
// Nibble to active-low 7-segment code, purely combinational.
// Latency: zero cycles. There is no handshake.
// When hex_mode is 0, codes 10..15 decode to blank.
module seg7_encoder
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             hex_mode,
  output logic [SEG_W-1:0] seg_n
);

  // Look up the glyph. Letters are only shown in hex mode.
  always_comb begin
    seg_n = SEG_BLANK;
    case (nibble)
      4'h0: seg_n = SEG_0;
      4'h1: seg_n = SEG_1;
      4'h2: seg_n = SEG_2;
      4'h3: seg_n = SEG_3;
      4'h4: seg_n = SEG_4;
      4'h5: seg_n = SEG_5;
      4'h6: seg_n = SEG_6;
      4'h7: seg_n = SEG_7;
      4'h8: seg_n = SEG_8;
      4'h9: seg_n = SEG_9;
      4'hA: seg_n = hex_mode ? SEG_A : SEG_BLANK;
      4'hB: seg_n = hex_mode ? SEG_B : SEG_BLANK;
      4'hC: seg_n = hex_mode ? SEG_C : SEG_BLANK;
      4'hD: seg_n = hex_mode ? SEG_D : SEG_BLANK;
      4'hE: seg_n = hex_mode ? SEG_E : SEG_BLANK;
      4'hF: seg_n = hex_mode ? SEG_F : SEG_BLANK;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with leading-zero blanking and frame-synchronous updates.
// Latency: outputs are registered and show the current digit index one cycle later.
// Loads are always accepted; a new value reaches the display only at the next frame wrap.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int HEX_MODE      = 0,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    en,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int DW  = $clog2(REFRESH_DIV);
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DGW = 4 * NUM_DIGITS;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic          AN_LOW   = (AN_ACTIVE_LOW != 0);
  localparam logic          HEX_ON   = (HEX_MODE != 0);

  logic [DW-1:0]         div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DGW-1:0]        shadow_dig_q, shadow_dig_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [DGW-1:0]        pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  tick_q, tick_d;

  logic                  div_end;
  logic                  wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  lz_blank;
  logic [NUM_DIGITS-1:0] an_on;
  logic [NUM_DIGITS-1:0] zero_from;
  logic [SEG_W-1:0]      enc_seg;

  // Scan timing. Divider and index advance only while enabled; the last digit wraps to digit 0.
  always_comb begin
    div_end = (div_q == DIV_LAST);
    wrap    = en && div_end && (idx_q == IDX_LAST);
    div_d   = div_q;
    idx_d   = idx_q;
    if (en) begin
      if (div_end) begin
        div_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Loads park in pending and move to shadow only at a wrap, so a frame never mixes old and new values.
  // A load on the wrap cycle itself goes straight to shadow.
  always_comb begin
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_vld_d   = pend_vld_q;
    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    if (load) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
    if (wrap) begin
      pend_vld_d = 1'b0;
      if (load) begin
        shadow_dig_d = digits_in;
        shadow_dp_d  = dp_in;
      end else if (pend_vld_q) begin
        shadow_dig_d = pend_dig_q;
        shadow_dp_d  = pend_dp_q;
      end
    end
  end

  // Pick the active digit and decide whether it is a leading zero.
  // zero_from[i] is set when digits i and above are all zero.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    lz_blank  = 1'b0;
    an_on     = '0;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (i == NUM_DIGITS - 1) begin
        zero_from[i] = (shadow_dig_q[4*i +: 4] == 4'h0);
      end else begin
        zero_from[i] = zero_from[i+1] && (shadow_dig_q[4*i +: 4] == 4'h0);
      end
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        cur_nib  = shadow_dig_q[4*i +: 4];
        cur_dp   = shadow_dp_q[i];
        lz_blank = blank_lz && (i != 0) && zero_from[i];
        an_on[i] = 1'b1;
      end
    end
  end

  seg7_encoder u_enc (
    .nibble   (cur_nib),
    .hex_mode (HEX_ON),
    .seg_n    (enc_seg)
  );

  // Next output values. While disabled the display is dark and no frame tick is raised.
  always_comb begin
    seg_d  = SEG_BLANK;
    dp_d   = 1'b1;
    an_d   = AN_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    tick_d = 1'b0;
    if (en) begin
      seg_d  = lz_blank ? SEG_BLANK : enc_seg;
      dp_d   = ~cur_dp;
      an_d   = AN_LOW ? ~an_on : an_on;
      tick_d = wrap;
    end
  end

  // All state. Reset darkens the display immediately and clears every stored value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= '0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_vld_q   <= 1'b0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= AN_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
      tick_q       <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      tick_q       <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 4 cycles per digit).
// A BCD instance and a hex instance share the same stimulus.
// A frame-arithmetic model checks every cycle; fixed vectors and hand-written sequences cover the corner cases.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int FR = N * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        en = 1'b0;

  logic [6:0] seg_b, seg_h;
  logic       dp_b, dp_h, tick_b, tick_h;
  logic [3:0] an_b, an_h;

  int total = 0;
  int bad   = 0;

  // Model state: enabled-cycle count plus shadow and pending values.
  int          ref_t;
  logic [15:0] m_shadow, m_pend;
  logic [3:0]  m_sdp, m_pdp;
  bit          m_pv;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dpv;
    logic        blz;
    logic [27:0] exp_seg;   // BCD instance, {digit3, digit2, digit1, digit0}
    logic [27:0] exp_hex;   // hex instance
  } vec_t;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .HEX_MODE(0), .AN_ACTIVE_LOW(1)) u_bcd (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .en(en), .seg(seg_b), .dp(dp_b), .an(an_b), .frame_tick(tick_b)
  );

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .HEX_MODE(1), .AN_ACTIVE_LOW(1)) u_hex (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .en(en), .seg(seg_h), .dp(dp_h), .an(an_h), .frame_tick(tick_h)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] n, input bit hex);
    logic [6:0] tbl [16];
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    if (!hex && n > 4'd9) return 7'b1111111;
    return tbl[n];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ref_t = 0; m_shadow = '0; m_pend = '0; m_sdp = '0; m_pdp = '0; m_pv = 0;
  endtask

  // One clock edge: predict the outputs from the model, sample the DUTs, then advance the model.
  task automatic step();
    int p, idx;
    logic [6:0] es0, es1;
    logic edp, etick, wrap, blank;
    logic [3:0] ean, nib;
    p = ref_t % FR;
    idx = p / RD;
    if (en) begin
      nib   = 4'(m_shadow >> (4 * idx));
      blank = blank_lz && (idx != 0) && ((m_shadow >> (4 * idx)) == 16'h0);
      es0   = blank ? 7'b1111111 : dec(nib, 0);
      es1   = blank ? 7'b1111111 : dec(nib, 1);
      edp   = ~m_sdp[idx];
      ean   = ~(4'b0001 << idx);
      etick = (p == FR - 1);
    end else begin
      es0 = 7'b1111111; es1 = 7'b1111111; edp = 1'b1; ean = 4'hF; etick = 1'b0;
    end
    @(posedge clk);
    #1;
    check("model_bcd", {19'd0, seg_b, dp_b, an_b, tick_b}, {19'd0, es0, edp, ean, etick});
    check("model_hex", {19'd0, seg_h, dp_h, an_h, tick_h}, {19'd0, es1, edp, ean, etick});
    wrap = en && (p == FR - 1);
    if (wrap) begin
      if (load) begin m_shadow = digits_in; m_sdp = dp_in; end
      else if (m_pv) begin m_shadow = m_pend; m_sdp = m_pdp; end
      m_pv = 0;
    end
    if (load) begin
      m_pend = digits_in; m_pdp = dp_in;
      if (!wrap) m_pv = 1;
    end
    if (en) ref_t++;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!tick_b && n < 2 * FR) begin
      step();
      n++;
    end
    if (!tick_b) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: no frame_tick within %0d cycles", 2 * FR);
    end
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 1'b0,
                {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100},
                {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
    vecs[1] = '{16'h0070, 4'b0000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001},
                {7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001}};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};
    vecs[3] = '{16'h00A5, 4'b0001, 1'b0,
                {7'b0000001, 7'b0000001, 7'b1111111, 7'b0100100},
                {7'b0000001, 7'b0000001, 7'b0001000, 7'b0100100}};
    vecs[4] = '{16'h00A5, 4'b0000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100},
                {7'b1111111, 7'b1111111, 7'b0001000, 7'b0100100}};
    vecs[5] = '{16'hFEDC, 4'b0101, 1'b0,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111},
                {7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001}};
    vecs[6] = '{16'h9086, 4'b1010, 1'b1,
                {7'b0000100, 7'b0000001, 7'b0000000, 7'b0100000},
                {7'b0000100, 7'b0000001, 7'b0000000, 7'b0100000}};
    vecs[7] = '{16'h0B00, 4'b1000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b0000001, 7'b0000001},
                {7'b1111111, 7'b1100000, 7'b0000001, 7'b0000001}};

    // Reset state
    @(posedge clk);
    #1;
    check("reset_bcd", {19'd0, seg_b, dp_b, an_b, tick_b}, {19'd0, 7'b1111111, 1'b1, 4'hF, 1'b0});
    check("reset_hex", {19'd0, seg_h, dp_h, an_h, tick_h}, {19'd0, 7'b1111111, 1'b1, 4'hF, 1'b0});
    rst = 1'b0;
    model_reset();
    en = 1'b1;

    // Table-driven vectors: load, wait for the swap, then check one full frame.
    for (int v = 0; v < 8; v++) begin
      digits_in = vecs[v].dig;
      dp_in     = vecs[v].dpv;
      blank_lz  = vecs[v].blz;
      load      = 1'b1;
      step();
      load = 1'b0;
      wait_tick();
      for (int s = 0; s < FR; s++) begin
        int d;
        logic [27:0] es, eh;
        logic [3:0] edpv;
        step();
        d = s / RD;
        es = vecs[v].exp_seg;
        eh = vecs[v].exp_hex;
        edpv = vecs[v].dpv;
        check("vector_frame", {14'd0, an_b, seg_b, seg_h, dp_b},
              {14'd0, ~(4'b0001 << d), es[7*d +: 7], eh[7*d +: 7], ~edpv[d]});
      end
    end

    // Tear-free update: a load in mid-frame must not change the frame already on the display.
    blank_lz = 1'b0;
    dp_in = 4'b0000;
    digits_in = 16'h1111;
    load = 1'b1;
    step();
    load = 1'b0;
    wait_tick();
    for (int s = 0; s < 5; s++) step();
    digits_in = 16'h2222;
    load = 1'b1;
    step();
    load = 1'b0;
    check("tear_old_seg", {25'd0, seg_b}, {25'd0, 7'b1001111});
    begin
      int n = 0;
      while (!tick_b && n < 2 * FR) begin
        step();
        n++;
        check("tear_old_seg", {25'd0, seg_b}, {25'd0, 7'b1001111});
      end
    end
    for (int s = 0; s < FR; s++) begin
      step();
      check("tear_new_frame", {24'd0, seg_b, tick_b}, {24'd0, 7'b0010010, (s == FR - 1)});
    end

    // A load on the wrap cycle is shown from digit 0 of the new frame.
    for (int s = 0; s < FR - 1; s++) step();
    digits_in = 16'h3333;
    load = 1'b1;
    step();
    load = 1'b0;
    check("wrapload_tick", {24'd0, seg_b, tick_b}, {24'd0, 7'b0010010, 1'b1});
    step();
    check("wrapload_new", {21'd0, an_b, seg_b}, {21'd0, 4'b1110, 7'b0000110});

    // Pause with the scan at digit 2, divider 1.
    for (int s = 0; s < 8; s++) step();
    en = 1'b0;
    for (int s = 0; s < 10; s++) begin
      step();
      check("pause_dark", {19'd0, an_b, seg_b, dp_b, tick_b}, {19'd0, 4'hF, 7'b1111111, 1'b1, 1'b0});
    end
    en = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      check("resume_digit2", {21'd0, an_b, seg_b}, {21'd0, 4'b1011, 7'b0000110});
    end
    step();
    check("resume_digit3", {28'd0, an_b}, {28'd0, 4'b0111});

    // Random stimulus against the model.
    for (int s = 0; s < 1500; s++) begin
      en = ($urandom_range(0, 15) != 0);
      load = ($urandom_range(0, 9) == 0);
      digits_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      step();
    end
    load = 1'b0;
    en = 1'b1;

    // Asynchronous reset in mid-frame.
    for (int s = 0; s < 5; s++) step();
    #2 rst = 1'b1;
    #1;
    check("async_rst_bcd", {19'd0, seg_b, dp_b, an_b, tick_b}, {19'd0, 7'b1111111, 1'b1, 4'hF, 1'b0});
    check("async_rst_hex", {19'd0, seg_h, dp_h, an_h, tick_h}, {19'd0, 7'b1111111, 1'b1, 4'hF, 1'b0});
    model_reset();
    #1 rst = 1'b0;
    blank_lz = 1'b1;
    for (int s = 0; s < 2 * FR; s++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
